iq_normalizer_pipe: RTL and testbench
=====================================

IQ_NORMALIZER_PIPE -- requirements
Module: iq_normalizer_pipe

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of channels (ch0 = I, ch1 = Q).
REQ-002 SHALL have parameter IN_W, default 32, signed accumulator width per channel.
REQ-003 SHALL have parameter OUT_W, default 18, signed normalized width per channel.
REQ-004 SHALL have parameter FRAME_LEN, default 1, samples emitted per start strobe.
REQ-005 SHALL have parameter SHIFT_INIT, default 11, reset value of the scale shift (0..15).
REQ-006 SHALL have parameter OFFSET_INIT, default all-ones (-1 as signed OUT_W+1 bits), reset value of every channel offset.
REQ-007 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port stb_start, input, 1, single-cycle frame start strobe.
REQ-010 SHALL have port in_valid, input, 1, accumulated_input is valid this cycle.
REQ-011 SHALL have port accumulated_input, input, N_CH*IN_W, channel k in bits [k*IN_W +: IN_W].
REQ-012 SHALL have ports cfg_we (1), cfg_ch (clog2 N_CH), cfg_offset (OUT_W+1), cfg_shift (4), all inputs, shadow config write.
REQ-013 SHALL have port normalized_output, output, N_CH*OUT_W, channel k in bits [k*OUT_W +: OUT_W].
REQ-014 SHALL have ports out_valid, NN_startTrigger, frame_done, sat_flag, outputs, 1 bit each.

Function
REQ-015 SHALL implement states IDLE, ARMED, RUN; reset to IDLE.
REQ-016 IDLE: stb_start -> ARMED; in_valid samples discarded (no out_valid).
REQ-017 ARMED: first in_valid sample enters the pipeline as frame sample 0; state -> RUN, or -> IDLE if FRAME_LEN = 1.
REQ-018 RUN: accept in_valid samples and count them; after sample FRAME_LEN-1 is accepted, state -> IDLE.
REQ-019 stb_start in ARMED or RUN SHALL be ignored; no restart, no counter change.
REQ-020 On stb_start, shadow offsets and shift SHALL be committed to active registers; a cfg_we in the same cycle SHALL land in shadow only and apply from the next frame.
REQ-021 cfg_we writes shadow offset[cfg_ch] and shared shadow shift; cfg_ch >= N_CH SHALL be ignored.
REQ-022 Pipeline per accepted sample: S1 capture x; S2 sum = sext(x) + sext(offset[k]) at IN_W+1 bits; S3 scaled = sum << shift at IN_W+16 bits; S4 output register.
REQ-023 Output value SHALL be scaled[2*OUT_W-1 : OUT_W] (bits [35:18] at defaults).
REQ-024 out_valid SHALL assert exactly 4 cycles after the accepting in_valid cycle, one cycle per sample; gaps in in_valid SHALL be preserved.
REQ-025 NN_startTrigger SHALL pulse together with out_valid of frame sample 0; frame_done SHALL pulse with out_valid of sample FRAME_LEN-1 (both same cycle when FRAME_LEN = 1).
REQ-026 normalized_output SHALL hold its last value while out_valid is low.
REQ-027 The sample counter SHALL be wide enough for FRAME_LEN and SHALL not wrap within a frame.

Reset
REQ-028 rst_n low SHALL immediately clear: state IDLE, counter 0, pipeline valids 0, outputs 0, sat_flag 0, active and shadow shift = SHIFT_INIT, offsets = OFFSET_INIT.
REQ-029 Reset mid-frame SHALL discard in-flight samples; no NN_startTrigger or frame_done after release until a new stb_start.

Configuration
REQ-030 With NORM_SAT_EN defined, if scaled bits above 2*OUT_W-1 differ from bit 2*OUT_W-1, the output SHALL clamp to +2^(OUT_W-1)-1 or -2^(OUT_W-1), and sat_flag SHALL set sticky until stb_start or reset.
REQ-031 Without NORM_SAT_EN, the output SHALL be the plain bit slice (wrap) and sat_flag SHALL be constant 0.

Verification
REQ-032 Defaults, stb_start, then in_valid with I=1000, Q=-1000 -> 4 cycles later out_valid with I=7, Q=-8, NN_startTrigger=1, frame_done=1.
REQ-033 in_valid without prior stb_start -> no out_valid, no trigger.
REQ-034 FRAME_LEN=4, stb_start, 4 samples with one idle gap -> 4 out_valid pulses with same gap; trigger on 1st, frame_done on 4th; 5th sample dropped.
REQ-035 I=2^30, default shift -> NORM_SAT_EN: I out 131071, sat_flag=1; without: I out -1, sat_flag=0.
REQ-036 cfg_we ch0 offset=0, shift=0 in the same cycle as stb_start -> current frame uses old config; next frame with I=2^18 gives I out 1.
REQ-037 rst_n low 2 cycles after accepting a sample -> no out_valid after release; all outputs 0.

Source files
------------

// File: rtl/iq_normalizer_pipe.sv
// iq_normalizer_pipe: framed per-channel offset, shift and slice normalizer on a 4-stage pipeline.
// Define NORM_SAT_EN to clamp overflowing outputs and raise a sticky sat_flag; default build wraps.
module iq_normalizer_pipe #(
    parameter int N_CH = 2,
    parameter int IN_W = 32,
    parameter int OUT_W = 18,
    parameter int FRAME_LEN = 1,
    parameter int SHIFT_INIT = 11,
    parameter logic [OUT_W:0] OFFSET_INIT = '1,
    localparam int CHW = N_CH > 1 ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stb_start,
    input  logic                    in_valid,
    input  logic [N_CH*IN_W-1:0]    accumulated_input,
    input  logic                    cfg_we,
    input  logic [CHW-1:0]          cfg_ch,
    input  logic [OUT_W:0]          cfg_offset,
    input  logic [3:0]              cfg_shift,
    output logic [N_CH*OUT_W-1:0]   normalized_output,
    output logic                    out_valid,
    output logic                    NN_startTrigger,
    output logic                    frame_done,
    output logic                    sat_flag
);
    localparam int CW = $clog2(FRAME_LEN + 1);
`ifdef NORM_SAT_EN
    localparam int HI = IN_W + 15;
`else
    localparam int HI = 2 * OUT_W - 1;
`endif
    localparam int SW = HI - OUT_W + 1;

    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic start, accept, first, last;

    assign start  = stb_start && state == IDLE;
    assign accept = in_valid && state != IDLE;
    assign first  = state == ARMED;
    assign last   = first ? (FRAME_LEN == 1) : (cnt == CW'(FRAME_LEN - 1));

    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = ARMED;
        else if (accept)
            state_nxt = last ? IDLE : RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= last ? '0 : cnt + CW'(1);
        end
    end

    // Shadow config is only committed when a frame actually starts.
    logic [OUT_W:0] sh_off [N_CH];
    logic [OUT_W:0] act_off [N_CH];
    logic [3:0] sh_shift, act_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_shift  <= 4'(SHIFT_INIT);
            act_shift <= 4'(SHIFT_INIT);
            for (int i = 0; i < N_CH; i++) begin
                sh_off[i]  <= OFFSET_INIT;
                act_off[i] <= OFFSET_INIT;
            end
        end else begin
            if (start) begin
                act_shift <= sh_shift;
                act_off   <= sh_off;
            end
            if (cfg_we && {1'b0, cfg_ch} < (CHW + 1)'(N_CH)) begin
                sh_shift       <= cfg_shift;
                sh_off[cfg_ch] <= cfg_offset;
            end
        end
    end

    // Shift travels with the sample so a commit right after a frame cannot touch its tail.
    logic v1, v2, v3, f1, f2, f3, l1, l2, l3;
    logic [3:0] sh2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v1, v2, v3, f1, f2, f3, l1, l2, l3} <= '0;
            sh2             <= '0;
            out_valid       <= 1'b0;
            NN_startTrigger <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            v1              <= accept;
            f1              <= accept && first;
            l1              <= accept && last;
            {v2, f2, l2}    <= {v1, f1, l1};
            {v3, f3, l3}    <= {v2, f2, l2};
            sh2             <= act_shift;
            out_valid       <= v3;
            NN_startTrigger <= v3 && f3;
            frame_done      <= v3 && l3;
        end
    end

`ifdef NORM_SAT_EN
    logic [N_CH-1:0] ovf;
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [IN_W-1:0]  x1;
        logic [IN_W:0]    sum2;
        logic [SW-1:0]    sc3;
        logic [OUT_W-1:0] val, q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                x1   <= '0;
                sum2 <= '0;
                sc3  <= '0;
                q    <= '0;
            end else begin
                x1   <= accumulated_input[k*IN_W +: IN_W];
                sum2 <= {x1[IN_W-1], x1} + {{(IN_W - OUT_W){act_off[k][OUT_W]}}, act_off[k]};
                sc3  <= SW'(({{15{sum2[IN_W]}}, sum2} << sh2) >> OUT_W);
                if (v3)
                    q <= val;
            end
        end
`ifdef NORM_SAT_EN
        assign ovf[k] = !(&sc3[SW-1:OUT_W-1] || ~|sc3[SW-1:OUT_W-1]);
        assign val = ovf[k] ? (sc3[SW-1] ? {1'b1, {(OUT_W - 1){1'b0}}} : {1'b0, {(OUT_W - 1){1'b1}}})
                            : sc3[OUT_W-1:0];
`else
        assign val = sc3[OUT_W-1:0];
`endif
        assign normalized_output[k*OUT_W +: OUT_W] = q;
    end

`ifdef NORM_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_flag <= 1'b0;
        else if (v3 && |ovf)
            sat_flag <= 1'b1;
        else if (stb_start)
            sat_flag <= 1'b0;
    end
`else
    assign sat_flag = 1'b0;
`endif
endmodule

// File: tb/tb_iq_normalizer_pipe.sv
// tb_iq_normalizer_pipe: directed checks of iq_normalizer_pipe (FRAME_LEN=1 and FRAME_LEN=4 instances).
module tb_iq_normalizer_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stb_a = 1'b0, iv_a = 1'b0, stb_b = 1'b0, iv_b = 1'b0;
    logic [63:0] din = '0;
    logic cfg_we = 1'b0;
    logic [0:0] cfg_ch = '0;
    logic [18:0] cfg_offset = '0;
    logic [3:0] cfg_shift = '0;
    logic [35:0] oa, ob;
    logic ova, tra, fda, sata, ovb, trb, fdb, satb;
    logic signed [17:0] ai, aq, bi, bq;
    int total = 0, bad = 0;

`ifdef NORM_SAT_EN
    localparam int SAT_I = 131071;
    localparam int SAT_F = 1;
`else
    localparam int SAT_I = -1;
    localparam int SAT_F = 0;
`endif

    assign ai = oa[17:0];
    assign aq = oa[35:18];
    assign bi = ob[17:0];
    assign bq = ob[35:18];

    always #5 clk = ~clk;

    iq_normalizer_pipe u_a (
        .clk(clk), .rst_n(rst_n), .stb_start(stb_a), .in_valid(iv_a), .accumulated_input(din),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_offset(cfg_offset), .cfg_shift(cfg_shift),
        .normalized_output(oa), .out_valid(ova), .NN_startTrigger(tra), .frame_done(fda),
        .sat_flag(sata)
    );

    iq_normalizer_pipe #(.FRAME_LEN(4)) u_b (
        .clk(clk), .rst_n(rst_n), .stb_start(stb_b), .in_valid(iv_b), .accumulated_input(din),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_offset(cfg_offset), .cfg_shift(cfg_shift),
        .normalized_output(ob), .out_valid(ovb), .NN_startTrigger(trb), .frame_done(fdb),
        .sat_flag(satb)
    );

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_a;
        stb_a = 1'b1;
        tick();
        stb_a = 1'b0;
    endtask

    task automatic send_a(input int i, input int q);
        din = {q, i};
        iv_a = 1'b1;
        tick();
        iv_a = 1'b0;
    endtask

    task automatic wait_a(output int n);
        n = 0;
        while (!ova && n < 10) begin
            tick();
            n++;
        end
    endtask

    task automatic quiet_a(input int cycles, output int hits);
        hits = 0;
        repeat (cycles) begin
            tick();
            hits += int'(ova) + int'(tra) + int'(fda);
        end
    endtask

    initial begin
        int n;
        logic [11:0] ov_h, tr_h, fd_h;
        logic signed [17:0] last_i, last_q;
        logic [5:0] pat;
        pat = 6'b111011;
        repeat (2) tick();
        check("rst_valid", ova, 0);
        check("rst_trig", tra, 0);
        check("rst_done", fda, 0);
        check("rst_out", oa, 0);
        check("rst_sat", sata, 0);
        rst_n = 1'b1;
        tick();

        send_a(1000, -1000);
        quiet_a(6, n);
        check("no_start_outputs", n, 0);

        start_a();
        send_a(1000, -1000);
        wait_a(n);
        check("latency", n, 3);
        check("basic_i", ai, 7);
        check("basic_q", aq, -8);
        check("basic_trig", tra, 1);
        check("basic_done", fda, 1);
        tick();
        check("valid_drops", ova, 0);
        check("hold_i", ai, 7);

        start_a();
        send_a(1 << 30, 0);
        wait_a(n);
        check("big_latency", n, 3);
        check("big_i", ai, SAT_I);
        check("big_q", aq, -1);
        check("big_sat", sata, SAT_F);
        start_a();
        check("sat_cleared", sata, 0);

        // Config written alongside the start strobe must wait for the next frame.
        cfg_we = 1'b1;
        cfg_ch = 1'b0;
        cfg_offset = '0;
        cfg_shift = 4'd0;
        start_a();
        cfg_we = 1'b0;
        send_a(1000, -1000);
        wait_a(n);
        check("old_cfg_i", ai, 7);
        check("old_cfg_q", aq, -8);
        start_a();
        send_a(1 << 18, 0);
        wait_a(n);
        check("new_cfg_i", ai, 1);
        check("new_cfg_q", aq, -1);

        start_a();
        send_a(1000, -1000);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out", oa, 0);
        check("midrst_valid", ova, 0);
        tick();
        rst_n = 1'b1;
        quiet_a(8, n);
        check("midrst_quiet", n, 0);
        check("midrst_hold", oa, 0);
        start_a();
        send_a(1000, -1000);
        wait_a(n);
        check("reinit_i", ai, 7);
        check("reinit_q", aq, -8);

        stb_b = 1'b1;
        tick();
        stb_b = 1'b0;
        ov_h = '0;
        tr_h = '0;
        fd_h = '0;
        last_i = '0;
        last_q = '0;
        for (int t = 0; t < 12; t++) begin
            iv_b = t < 6 ? pat[t] : 1'b0;
            din = t == 4 ? {32'(-2000), 32'(2000)} : {32'(-1000), 32'(1000)};
            tick();
            ov_h[t] = ovb;
            tr_h[t] = trb;
            fd_h[t] = fdb;
            if (t == 7) begin
                last_i = bi;
                last_q = bq;
            end
        end
        check("frame_valid_pattern", ov_h, 12'h0D8);
        check("frame_trig_pattern", tr_h, 12'h008);
        check("frame_done_pattern", fd_h, 12'h080);
        check("frame_last_i", last_i, 15);
        check("frame_last_q", last_q, -16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
